// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and FSM state encoding for the sequential ALU
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  function automatic logic is_known_op(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROL, OP_ROR, OP_SHR,
      OP_SHRA, OP_SHL, OP_DIV, OP_MUL, OP_NEG, OP_NOT: is_known_op = 1'b1;
      default: is_known_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - shared iteration engine: radix-2 Booth multiply and restoring divide
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic             is_div,
  input  logic             step,
  input  logic             fix,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  // acc carries one guard bit so Booth add/sub of the most-negative multiplicand cannot overflow
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] opnd;
  logic             q1;
  logic             div_mode;
  logic             neg_q;
  logic             neg_r;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   opnd_x;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_fit;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    opnd_x = {opnd[WIDTH-1], opnd};
    case ({sreg[0], q1})
      2'b01:   booth_sum = acc + opnd_x;
      2'b10:   booth_sum = acc - opnd_x;
      default: booth_sum = acc;
    endcase
    div_shift = {acc[WIDTH-1:0], sreg[WIDTH-1]};
    div_fit   = (div_shift >= {1'b0, opnd});
    abs_a     = a[WIDTH-1] ? -a : a;
    abs_b     = b[WIDTH-1] ? -b : b;
    quo_fix   = neg_q ? -sreg : sreg;
    rem_fix   = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      acc      <= '0;
      sreg     <= '0;
      opnd     <= '0;
      q1       <= 1'b0;
      div_mode <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      count    <= '0;
    end else if (load) begin
      acc      <= '0;
      q1       <= 1'b0;
      count    <= '0;
      div_mode <= is_div;
      if (is_div) begin
        sreg  <= abs_a;
        opnd  <= abs_b;
        neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
        neg_r <= a[WIDTH-1];
      end else begin
        sreg  <= b;
        opnd  <= a;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end
    end else if (step) begin
      count <= count + 1'b1;
      if (div_mode) begin
        acc  <= div_fit ? (div_shift - {1'b0, opnd}) : div_shift;
        sreg <= {sreg[WIDTH-2:0], div_fit};
      end else begin
        {acc, sreg, q1} <= {booth_sum[WIDTH], booth_sum, sreg};
      end
    end else if (fix) begin
      acc  <= {1'b0, rem_fix};
      sreg <= quo_fix;
    end
  end

  assign last = (count == CW'(WIDTH - 1));
  assign hi   = acc[WIDTH-1:0];
  assign lo   = sreg;

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - multi-cycle ALU with start/busy/done handshake and HI/LO result split
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Zhigh,
  output logic [WIDTH-1:0] Zlow,
  output logic             div0,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic [4:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic             md_load;
  logic             md_is_div;
  logic             md_step;
  logic             md_fix;
  logic             md_last;
  logic [WIDTH-1:0] md_hi;
  logic [WIDTH-1:0] md_lo;

  assign md_load   = (state == ST_IDLE) && start &&
                     ((opcode == OP_MUL) || ((opcode == OP_DIV) && (B != '0)));
  assign md_is_div = (opcode == OP_DIV);
  assign md_step   = (state == ST_MUL) || (state == ST_DIV);
  assign md_fix    = (state == ST_FIX);

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock  (clock),
    .clear  (clear),
    .load   (md_load),
    .is_div (md_is_div),
    .step   (md_step),
    .fix    (md_fix),
    .a      (A),
    .b      (B),
    .last   (md_last),
    .hi     (md_hi),
    .lo     (md_lo)
  );

  logic [SHW-1:0]     amt;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] dbl_r;
  logic [2*WIDTH-1:0] dbl_l;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;
  logic               res_div0;
  logic               res_ill;

  // {A,A} shifted gives the rotate in one half and the plain logical shift in the other
  always_comb begin
    amt      = b_r[SHW-1:0];
    dbl      = {a_r, a_r};
    dbl_r    = dbl >> amt;
    dbl_l    = dbl << amt;
    res_hi   = '0;
    res_lo   = '0;
    res_div0 = 1'b0;
    res_ill  = 1'b0;
    case (op_r)
      OP_AND:  res_lo = a_r & b_r;
      OP_OR:   res_lo = a_r | b_r;
      OP_ADD:  res_lo = a_r + b_r;
      OP_SUB:  res_lo = a_r - b_r;
      OP_SHR:  res_lo = dbl_r[2*WIDTH-1:WIDTH];
      OP_SHL:  res_lo = dbl_l[WIDTH-1:0];
      OP_SHRA: res_lo = $signed(a_r) >>> amt;
      OP_ROR:  res_lo = dbl_r[WIDTH-1:0];
      OP_ROL:  res_lo = dbl_l[2*WIDTH-1:WIDTH];
      OP_NEG:  res_lo = -b_r;
      OP_NOT:  res_lo = ~b_r;
      OP_MUL: begin
        res_hi = md_hi;
        res_lo = md_lo;
      end
      OP_DIV: begin
        if (b_r == '0) begin
          res_hi   = a_r;
          res_lo   = '1;
          res_div0 = 1'b1;
        end else begin
          res_hi = md_hi;
          res_lo = md_lo;
        end
      end
      default: res_ill = !is_known_op(op_r);
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state   <= ST_IDLE;
      op_r    <= '0;
      a_r     <= '0;
      b_r     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Zhigh   <= '0;
      Zlow    <= '0;
      div0    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r    <= opcode;
            a_r     <= A;
            b_r     <= B;
            busy    <= 1'b1;
            div0    <= 1'b0;
            illegal <= 1'b0;
            if (opcode == OP_MUL)
              state <= ST_MUL;
            else if ((opcode == OP_DIV) && (B != '0))
              state <= ST_DIV;
            else
              state <= ST_DONE;
          end
        end
        ST_MUL: if (md_last) state <= ST_DONE;
        ST_DIV: if (md_last) state <= ST_FIX;
        ST_FIX: state <= ST_DONE;
        ST_DONE: begin
          Zhigh   <= res_hi;
          Zlow    <= res_lo;
          div0    <= res_div0;
          illegal <= res_ill;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
